// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one word-aligned fetch at a
// time over a req/ready handshake, collects rvalid responses into a small
// FIFO toward the decoder, and handles redirects by flushing buffered
// instructions and discarding the response of any request already accepted.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
  localparam logic [31:0] RESET_PC_AL = RESET_PC & ~32'h3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic               imem_req_q, imem_req_d;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   count_nxt;
  logic [31:0]        buf_inst_q [BUF_DEPTH];
  logic [31:0]        buf_pc_q   [BUF_DEPTH];

  logic               accept;
  logic               resp_in_wait;
  logic               push;
  logic               pop;
  logic               space_after;

  // The outstanding request is accepted only from REQ; imem_req mirrors it.
  assign accept       = (state_q == S_REQ) && imem_ready;
  assign resp_in_wait = (state_q == S_WAIT) && imem_rvalid;

  // A redirect kills both the push of an arriving response and the pop
  // of the current head: neither belongs to the new instruction stream.
  assign push = resp_in_wait && !redirect_valid;
  assign pop  = inst_valid && inst_ready && !redirect_valid;

  // Occupancy after this cycle's push/pop, used to decide whether another
  // request may be issued (a slot is reserved for its response).
  assign count_nxt   = count_q + CNT_W'(push) - CNT_W'(pop);
  assign space_after = (count_nxt < DEPTH_C);

  // Next-state logic for the fetch FSM and PC; redirect takes priority.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~32'h3;
      unique case (state_q)
        S_IDLE:  state_d = S_REQ;
        S_REQ:   state_d = imem_ready  ? S_DRAIN : S_REQ;
        S_WAIT:  state_d = imem_rvalid ? S_REQ   : S_DRAIN;
        S_DRAIN: state_d = imem_rvalid ? S_REQ   : S_DRAIN;
        default: state_d = S_IDLE;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (count_q < DEPTH_C) state_d = S_REQ;
        end
        S_REQ: begin
          if (imem_ready) begin
            state_d  = S_WAIT;
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) state_d = space_after ? S_REQ : S_IDLE;
        end
        S_DRAIN: begin
          if (imem_rvalid) state_d = S_REQ;
        end
        default: state_d = S_IDLE;
      endcase
    end
    imem_req_d = (state_d == S_REQ);
  end

  // FSM, PC and registered request outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC_AL;
      req_pc_q   <= RESET_PC_AL;
      imem_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      imem_req_q <= imem_req_d;
    end
  end

  // While a request is pending the PC has not advanced yet, so the PC
  // register is the request address.
  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;

  // FIFO pointer/occupancy next state; a redirect empties the FIFO.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_nxt;
    end
  end

  // FIFO control registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents only matter while counted, so no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      buf_inst_q[wr_ptr_q] <= imem_rdata;
      buf_pc_q[wr_ptr_q]   <= req_pc_q;
    end
  end

  // Head of FIFO toward the decoder; zero when empty so reset and flush
  // present a clean all-zero instruction interface.
  assign inst_valid = (count_q != '0);
  assign inst_data  = inst_valid ? buf_inst_q[rd_ptr_q] : 32'h0;
  assign inst_pc    = inst_valid ? buf_pc_q[rd_ptr_q]   : 32'h0;

  // The reserved slot guarantees a response never lands in a full FIFO.
  assert property (@(posedge clock) disable iff (!reset_n)
                   !(push && (count_q == DEPTH_C)));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit with a stream-level reference:
// fetched addresses and delivered PCs must each follow a sequential stream
// that restarts at the redirect target, and data must match the memory image.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  always #5 clock = ~clock;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Stimulus knobs
  int          p_ready   = 100;
  int          p_iready  = 100;
  int          lat_fixed = 0;
  int          max_lat   = 0;
  int          p_redir   = 0;
  int          force_iready = -1;
  bit          force_redir  = 1'b0;
  logic [31:0] force_tgt    = 32'h0;
  bit          prev_redir   = 1'b0;

  // Memory model and stream reference
  bit          mem_pending = 1'b0;
  logic [31:0] mem_addr    = 32'h0;
  int          mem_lat     = 0;
  logic [31:0] exp_fetch   = 32'h0;
  logic [31:0] exp_deliver = 32'h0;
  bit          chk_empty   = 1'b0;
  bit          hold_pend   = 1'b0;
  logic [31:0] hold_addr   = 32'h0;
  bit          accepted    = 1'b0;
  logic [31:0] last_acc_addr = 32'h0;
  int          n_accept = 0;
  int          n_pop    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0000_0000: memf = 32'h0020_81B3;
      32'h0000_0004: memf = 32'h4030_8233;
      default:       memf = (a * 32'd2654435761) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  // One clock cycle: drive at negedge, evaluate handshakes 1 time unit later.
  task automatic step();
    @(negedge clock);
    imem_ready = (int'($urandom_range(99)) < p_ready);
    inst_ready = (force_iready >= 0) ? force_iready[0] : (int'($urandom_range(99)) < p_iready);
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_tgt;
      force_redir    = 1'b0;
    end else begin
      redirect_valid = !prev_redir && (int'($urandom_range(999)) < p_redir);
      redirect_pc    = $urandom;
    end
    prev_redir = redirect_valid;
    if (mem_pending && mem_lat == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(mem_addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    accepted = 1'b0;
    if (chk_empty) begin
      check("flush_empty", {31'h0, inst_valid}, 32'h0);
      chk_empty = 1'b0;
    end
    if (hold_pend) begin
      check("req_hold", {31'h0, imem_req}, 32'h1);
      check("addr_hold", imem_addr, hold_addr);
    end
    hold_pend = imem_req && !imem_ready && !redirect_valid;
    hold_addr = imem_addr;
    if (mem_pending) begin
      if (imem_rvalid) mem_pending = 1'b0;
      else             mem_lat--;
    end
    if (imem_req && imem_ready) begin
      check("one_outstanding", {31'h0, mem_pending}, 32'h0);
      check("fetch_addr", imem_addr, exp_fetch);
      exp_fetch     = exp_fetch + 32'd4;
      mem_pending   = 1'b1;
      mem_addr      = imem_addr;
      mem_lat       = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(max_lat));
      accepted      = 1'b1;
      last_acc_addr = imem_addr;
      n_accept++;
    end
    if (inst_valid && inst_ready && !redirect_valid) begin
      check("inst_pc", inst_pc, exp_deliver);
      check("inst_data", inst_data, memf(exp_deliver));
      exp_deliver = exp_deliver + 32'd4;
      n_pop++;
    end
    if (redirect_valid) begin
      exp_fetch   = redirect_pc & ~32'h3;
      exp_deliver = redirect_pc & ~32'h3;
      chk_empty   = 1'b1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_accept();
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!accepted && k < 60);
    if (!accepted) check("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'h0, imem_req},   32'h0);
    check({tag, "_addr"},  imem_addr,           32'h0);
    check({tag, "_valid"}, {31'h0, inst_valid}, 32'h0);
    check({tag, "_data"},  inst_data,           32'h0);
    check({tag, "_pc"},    inst_pc,             32'h0);
  endtask

  task automatic clear_model();
    mem_pending = 1'b0;
    exp_fetch   = 32'h0;
    exp_deliver = 32'h0;
    chk_empty   = 1'b0;
    hold_pend   = 1'b0;
    prev_redir  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap_acc, snap_pop;
    reset_n = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1 check_reset_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Streaming: steady state yields one instruction every two cycles.
    p_ready = 100; p_iready = 100; lat_fixed = 0; p_redir = 0;
    run(6);
    snap_pop = n_pop;
    run(20);
    check("throughput", n_pop - snap_pop, 32'd10);

    // Decoder stall: FIFO fills with exactly two entries, then fetch stops.
    p_iready = 0;
    force_redir = 1'b1; force_tgt = 32'h0;
    step();
    snap_acc = n_accept;
    run(11);
    check("stall_accepts", n_accept - snap_acc, 32'd2);
    check("stall_req_low", {31'h0, imem_req}, 32'h0);
    check("stall_head_valid", {31'h0, inst_valid}, 32'h1);
    check("stall_head_pc", inst_pc, 32'h0);

    // Drain while memory is not ready: request at 0x8 held stable.
    p_iready = 100; p_ready = 0;
    run(6);
    check("held_req", {31'h0, imem_req}, 32'h1);
    check("held_addr", imem_addr, 32'h8);
    p_ready = 100;
    snap_acc = n_accept;
    step();
    check("held_accept", n_accept - snap_acc, 32'd1);

    // Redirect while waiting for a response.
    lat_fixed = 2;
    wait_accept();
    force_redir = 1'b1; force_tgt = 32'h103;
    step();
    lat_fixed = 0;
    snap_pop = n_pop;
    wait_accept();
    check("redir_wait_addr", last_acc_addr, 32'h100);
    run(12);
    check("redir_progress", {31'h0, n_pop > snap_pop}, 32'h1);

    // Redirect coinciding with a response and a decoder pop.
    force_iready = 0; lat_fixed = 0; p_ready = 100;
    begin
      int k;
      k = 0;
      do begin
        step();
        k++;
      end while (!(accepted && inst_valid) && k < 60);
      check("combo_reach", {31'h0, accepted && inst_valid}, 32'h1);
    end
    force_iready = 1; force_redir = 1'b1; force_tgt = 32'h200;
    step();
    check("combo_setup", {29'h0, imem_rvalid, inst_valid, inst_ready}, 32'h7);
    force_iready = -1; p_iready = 100;
    wait_accept();
    check("combo_target", last_acc_addr, 32'h200);
    run(10);

    // PC wraparound.
    force_redir = 1'b1; force_tgt = 32'hFFFF_FFFC;
    step();
    wait_accept();
    check("wrap_first", last_acc_addr, 32'hFFFF_FFFC);
    wait_accept();
    check("wrap_second", last_acc_addr, 32'h0000_0000);
    run(8);

    // Asynchronous reset while a response is outstanding.
    lat_fixed = 3;
    wait_accept();
    #6;
    reset_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    clear_model();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    imem_ready = 1'b0; redirect_valid = 1'b0;
    lat_fixed = 0;
    wait_accept();
    check("restart_addr", last_acc_addr, 32'h0);
    snap_pop = n_pop;
    run(20);
    check("restart_progress", {31'h0, n_pop > snap_pop}, 32'h1);

    // Randomized traffic with random redirects and latencies.
    lat_fixed = -1;
    for (int blk = 0; blk < 15; blk++) begin
      p_ready  = 30 + int'($urandom_range(70));
      p_iready = 20 + int'($urandom_range(80));
      max_lat  = int'($urandom_range(3));
      p_redir  = int'($urandom_range(30));
      run(200);
    end
    check("random_progress", {31'h0, n_pop > 100}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
